// File: rtl/mem_access_unit_if.sv
// Bus between the multicycle datapath/memory and mem_access_unit.
// master = datapath plus memory side; slave = the access unit.
interface mem_access_unit_if;
   logic        req;
   logic        is_fetch;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic [31:0] instr;
   logic [31:0] load_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport master (
      output req, is_fetch, is_store, funct3, addr, store_data, mem_rdata,
      input  busy, done, misaligned, instr, load_data, mem_addr, mem_wdata, mem_read, mem_write
   );

   modport slave (
      input  req, is_fetch, is_store, funct3, addr, store_data, mem_rdata,
      output busy, done, misaligned, instr, load_data, mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences fetch/load/store as single memory transactions; sub-word stores use read-modify-write.
// Optional macro MAU_MISALIGN_TRAP_EN: detect and suppress misaligned accesses.
module mem_access_unit #(
   parameter int unsigned MEM_AW = 8
) (
   input logic              clk,
   input logic              reset_n,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

   localparam logic [1:0] SzByte = 2'd0;
   localparam logic [1:0] SzHalf = 2'd1;
   localparam logic [1:0] SzWord = 2'd2;

   state_e              state_q, state_d;
   logic                fetch_q, fetch_d;
   logic                store_q, store_d;
   logic                unsigned_q, unsigned_d;
   logic [1:0]          size_q, size_d;
   logic [MEM_AW-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         ir_q, ir_d;
   logic [31:0]         mdr_q, mdr_d;
   logic                mis_q, mis_d;
   logic [31:0]         last_addr_q, last_addr_d;

   logic [31:0] aligned;
   logic [31:0] merged;
   logic [31:0] ext;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [1:0]  req_size;
   logic        req_mis;

   always_comb begin
      state_d     = state_q;
      fetch_d     = fetch_q;
      store_d     = store_q;
      unsigned_d  = unsigned_q;
      size_d      = size_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ir_d        = ir_q;
      mdr_d       = mdr_q;
      mis_d       = mis_q;
      last_addr_d = last_addr_q;

      bus.busy       = (state_q != StIdle);
      bus.done       = 1'b0;
      bus.misaligned = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_wdata  = '0;
      bus.instr      = ir_q;
      bus.load_data  = mdr_q;

      aligned = '0;
      aligned[MEM_AW-1:2] = addr_q[MEM_AW-1:2];
      bus.mem_addr = last_addr_q;

      // Invalid funct3 codes fall into the word case along with 010.
      if (bus.is_fetch)                req_size = SzWord;
      else if (bus.funct3[1:0] == 2'b00) req_size = SzByte;
      else if (bus.funct3[1:0] == 2'b01) req_size = SzHalf;
      else                              req_size = SzWord;

`ifdef MAU_MISALIGN_TRAP_EN
      req_mis = ((req_size == SzWord) && (bus.addr[1:0] != 2'b00)) ||
                ((req_size == SzHalf) && bus.addr[0]);
`else
      req_mis = 1'b0;
`endif

      lane_b = 8'(bus.mem_rdata >> {addr_q[1:0], 3'b000});
      lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

      merged = bus.mem_rdata;
      if (size_q == SzByte) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];

      if (size_q == SzByte)      ext = {{24{~unsigned_q & lane_b[7]}}, lane_b};
      else if (size_q == SzHalf) ext = {{16{~unsigned_q & lane_h[15]}}, lane_h};
      else                       ext = bus.mem_rdata;

      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               fetch_d    = bus.is_fetch;
               store_d    = bus.is_store & ~bus.is_fetch;
               unsigned_d = bus.funct3[2];
               size_d     = req_size;
               addr_d     = bus.addr[MEM_AW-1:0];
               wdata_d    = bus.store_data;
               mis_d      = req_mis;
               if (req_mis)
                  state_d = StFin;
               else if (bus.is_store && !bus.is_fetch && req_size == SzWord)
                  state_d = StWrite;
               else
                  state_d = StRead;
            end
         end
         StRead: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = aligned;
            last_addr_d  = aligned;
            if (fetch_q) begin
               ir_d    = bus.mem_rdata;
               state_d = StFin;
            end else if (store_q) begin
               wdata_d = merged;
               state_d = StWrite;
            end else begin
               mdr_d   = ext;
               state_d = StFin;
            end
         end
         StWrite: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = aligned;
            bus.mem_wdata = wdata_q;
            last_addr_d   = aligned;
            state_d       = StFin;
         end
         StFin: begin
            bus.done       = 1'b1;
            bus.misaligned = mis_q;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         fetch_q     <= 1'b0;
         store_q     <= 1'b0;
         unsigned_q  <= 1'b0;
         size_q      <= SzWord;
         addr_q      <= '0;
         wdata_q     <= '0;
         ir_q        <= 32'h0000_0013;
         mdr_q       <= '0;
         mis_q       <= 1'b0;
         last_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_q     <= fetch_d;
         store_q     <= store_d;
         unsigned_q  <= unsigned_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ir_q        <= ir_d;
         mdr_q       <= mdr_d;
         mis_q       <= mis_d;
         last_addr_q <= last_addr_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle expectation queue from a transaction-level model,
// plus literal spot checks of final register values.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus ();

   mem_access_unit #(.MEM_AW(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   // Byte-addressed memory, combinational read, synchronous 4-byte write.
   logic [7:0] mem [256];
   always_comb begin
      bus.mem_rdata = {mem[{bus.mem_addr[7:2], 2'b11}], mem[{bus.mem_addr[7:2], 2'b10}],
                       mem[{bus.mem_addr[7:2], 2'b01}], mem[{bus.mem_addr[7:2], 2'b00}]};
   end
   always @(posedge clk) begin
      if (bus.mem_write) begin
         mem[{bus.mem_addr[7:2], 2'b00}] <= bus.mem_wdata[7:0];
         mem[{bus.mem_addr[7:2], 2'b01}] <= bus.mem_wdata[15:8];
         mem[{bus.mem_addr[7:2], 2'b10}] <= bus.mem_wdata[23:16];
         mem[{bus.mem_addr[7:2], 2'b11}] <= bus.mem_wdata[31:24];
      end
   end

   typedef struct {
      bit          rd;
      bit          wr;
      bit          dn;
      bit          mis;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] ir;
      logic [31:0] mdr;
   } ph_t;

   ph_t         q[$];
   logic [31:0] m_ir = 32'h0000_0013;
   logic [31:0] m_mdr = '0;
   logic [31:0] last_addr = '0;
   bit          chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ph_t mk(bit rd, bit wr, bit dn, bit mis, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] ir, logic [31:0] mdr);
      ph_t p;
      p.rd = rd; p.wr = wr; p.dn = dn; p.mis = mis;
      p.addr = a; p.wdata = wd; p.ir = ir; p.mdr = mdr;
      return p;
   endfunction

   function automatic logic [31:0] rdword(logic [31:0] a);
      int b;
      b = int'(a[7:0]) & 252;
      return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
   endfunction

   task automatic wrword(input logic [31:0] a, input logic [31:0] w);
      int b;
      b = int'(a[7:0]) & 252;
      mem[b] = w[7:0]; mem[b+1] = w[15:8]; mem[b+2] = w[23:16]; mem[b+3] = w[31:24];
   endtask

   // Compare process: one expected phase per cycle while busy, idle expectations otherwise.
   ph_t p;
   bit  act;
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         if (q.size() > 0) begin
            p = q.pop_front();
            act = 1'b1;
         end else begin
            p = mk(0, 0, 0, 0, 0, 0, m_ir, m_mdr);
            act = 1'b0;
         end
         chk("busy", 32'(bus.busy), 32'(act));
         chk("done", 32'(bus.done), 32'(p.dn));
         chk("misaligned", 32'(bus.misaligned), 32'(p.mis));
         chk("mem_read", 32'(bus.mem_read), 32'(p.rd));
         chk("mem_write", 32'(bus.mem_write), 32'(p.wr));
         chk("mem_wdata", bus.mem_wdata, p.wr ? p.wdata : 32'h0);
         chk("mem_addr", bus.mem_addr, (p.rd || p.wr) ? p.addr : last_addr);
         chk("instr", bus.instr, p.ir);
         chk("load_data", bus.load_data, p.mdr);
         if (p.rd || p.wr) last_addr = p.addr;
      end
   end

   // Transaction-level model plus driver; entered and left at a falling edge.
   task automatic txn(input bit f, input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input bit hold, input bit rst_mid);
      int          size;
      bit          uns;
      bit          mis;
      int          sh;
      logic [31:0] wa, w, v, mrg, mask;
      int          n;
      if (f) size = 4;
      else if (f3 == 3'b000 || f3 == 3'b100) size = 1;
      else if (f3 == 3'b001 || f3 == 3'b101) size = 2;
      else size = 4;
      uns = (f3 == 3'b100 || f3 == 3'b101);
`ifdef MAU_MISALIGN_TRAP_EN
      mis = (size == 4 && a[1:0] != 2'b00) || (size == 2 && a[0]);
`else
      mis = 1'b0;
`endif
      wa = {24'h0, a[7:2], 2'b00};
      w  = rdword(a);
      sh = (size == 1) ? 8 * int'(a[1:0]) : (size == 2) ? 16 * int'(a[1]) : 0;
      mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      bus.req = 1'b1; bus.is_fetch = f; bus.is_store = st; bus.funct3 = f3;
      bus.addr = a; bus.store_data = sd;
      if (mis) begin
         q.push_back(mk(0, 0, 1, 1, 0, 0, m_ir, m_mdr));
      end else if (f) begin
         q.push_back(mk(1, 0, 0, 0, wa, 0, m_ir, m_mdr));
         if (!rst_mid) begin
            m_ir = w;
            q.push_back(mk(0, 0, 1, 0, 0, 0, m_ir, m_mdr));
         end
      end else if (st && size == 4) begin
         q.push_back(mk(0, 1, 0, 0, wa, sd, m_ir, m_mdr));
         q.push_back(mk(0, 0, 1, 0, 0, 0, m_ir, m_mdr));
      end else if (st) begin
         mrg = (w & ~(mask << sh)) | ((sd & mask) << sh);
         q.push_back(mk(1, 0, 0, 0, wa, 0, m_ir, m_mdr));
         if (!rst_mid) begin
            q.push_back(mk(0, 1, 0, 0, wa, mrg, m_ir, m_mdr));
            q.push_back(mk(0, 0, 1, 0, 0, 0, m_ir, m_mdr));
         end
      end else begin
         v = (w >> sh) & mask;
         if (!uns && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (!uns && size == 2 && v[15]) v = v | 32'hFFFF_0000;
         q.push_back(mk(1, 0, 0, 0, wa, 0, m_ir, m_mdr));
         if (!rst_mid) begin
            m_mdr = v;
            q.push_back(mk(0, 0, 1, 0, 0, 0, m_ir, m_mdr));
         end
      end
      @(negedge clk);
      if (!hold) bus.req = 1'b0;
      if (rst_mid) begin
         reset_n = 1'b0;
         m_ir = 32'h0000_0013;
         m_mdr = '0;
         last_addr = '0;
      end
      n = 0;
      while (q.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("timeout_queue", 32'(q.size()), 32'h0);
         q.delete();
      end
      @(negedge clk);
      bus.req = 1'b0;
      reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      wrword(32'h00, 32'h0040_0293);
      wrword(32'h04, 32'h0050_0313);
      wrword(32'h80, 32'h00F0_8000);
      wrword(32'h84, 32'h5566_7788);
      bus.req = 1'b0; bus.is_fetch = 1'b0; bus.is_store = 1'b0;
      bus.funct3 = 3'b000; bus.addr = '0; bus.store_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_instr", bus.instr, 32'h0000_0013);
      chk("rst_load_data", bus.load_data, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      reset_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      txn(1, 0, 3'b010, 32'h00, 0, 0, 0);                 // fetch
      chk("fetch_instr", bus.instr, 32'h0040_0293);
      chk("fetch_ldata", bus.load_data, 32'h0);
      txn(0, 0, 3'b000, 32'h81, 0, 0, 0);                 // lb
      chk("lb", bus.load_data, 32'hFFFF_FF80);
      txn(0, 0, 3'b100, 32'h81, 0, 0, 0);                 // lbu
      chk("lbu", bus.load_data, 32'h0000_0080);
      txn(0, 0, 3'b101, 32'h82, 0, 0, 0);                 // lhu
      chk("lhu", bus.load_data, 32'h0000_00F0);
      txn(0, 0, 3'b001, 32'h80, 0, 0, 0);                 // lh
      chk("lh", bus.load_data, 32'hFFFF_8000);

      wrword(32'h80, 32'h1122_3344);
      txn(0, 1, 3'b000, 32'h83, 32'h0000_00AB, 0, 0);     // sb
      txn(0, 0, 3'b010, 32'h80, 0, 0, 0);
      chk("sb_then_lw", bus.load_data, 32'hAB22_3344);
      txn(0, 1, 3'b001, 32'h86, 32'h1234_CAFE, 0, 0);     // sh upper half
      txn(0, 0, 3'b010, 32'h84, 0, 0, 0);
      chk("sh_then_lw", bus.load_data, 32'hCAFE_7788);
      txn(0, 1, 3'b010, 32'h90, 32'hDEAD_BEEF, 0, 0);     // sw
      txn(0, 0, 3'b010, 32'h90, 0, 0, 0);
      chk("sw_then_lw", bus.load_data, 32'hDEAD_BEEF);

      txn(0, 0, 3'b010, 32'h86, 0, 0, 0);                 // misaligned lw
`ifdef MAU_MISALIGN_TRAP_EN
      chk("mis_lw_ldata", bus.load_data, 32'hDEAD_BEEF);
`else
      chk("mis_lw_ldata", bus.load_data, 32'hCAFE_7788);
`endif
      txn(0, 1, 3'b001, 32'h81, 32'h0000_5A5A, 0, 0);     // misaligned sh
      txn(0, 0, 3'b010, 32'h80, 0, 0, 0);
`ifdef MAU_MISALIGN_TRAP_EN
      chk("mis_sh_word", bus.load_data, 32'hAB22_3344);
`else
      chk("mis_sh_word", bus.load_data, 32'hAB22_5A5A);
`endif
      txn(0, 0, 3'b011, 32'h84, 0, 0, 0);                 // invalid funct3 acts as lw
      chk("f3_011", bus.load_data, 32'hCAFE_7788);
      txn(1, 1, 3'b000, 32'h04, 32'hFFFF_FFFF, 0, 0);     // fetch overrides store
      chk("fetch_ovr", bus.instr, 32'h0050_0313);
      chk("fetch_ovr_mem", rdword(32'h04), 32'h0050_0313);

      txn(0, 1, 3'b001, 32'h84, 32'h0000_1111, 0, 1);     // reset mid sh
      chk("rst_mid_instr", bus.instr, 32'h0000_0013);
      chk("rst_mid_ldata", bus.load_data, 32'h0);
      chk("rst_mid_mem", rdword(32'h84), 32'hCAFE_7788);
      txn(0, 0, 3'b100, 32'h83, 0, 1, 0);                 // req held through FIN
      chk("hold_lbu", bus.load_data, 32'h0000_00AB);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
